// File: rtl/regfile_snapshot_pkg.sv
// Shared types for the register-file snapshot controller: restore FSM states
// and the slot-index width helper.
package regfile_snapshot_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } snap_state_t;

   // Width of a slot index; never less than one bit so ports stay legal.
   function automatic int slot_idx_w(input int nslots);
      return (nslots > 2) ? $clog2(nslots) : 1;
   endfunction

endpackage

// File: rtl/regfile_snapshot_prio_enc.sv
// Finds the lowest-index clear bit of a slot occupancy mask.
module regfile_snapshot_prio_enc
   import regfile_snapshot_pkg::*;
#(
   parameter int NSLOTS = 4,
   localparam int SW = slot_idx_w(NSLOTS)
) (
   input  logic [NSLOTS-1:0] mask,
   output logic [SW-1:0]     idx,
   output logic              found
);

   // Scan downward so the last assignment is the lowest clear bit.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int s = NSLOTS - 1; s >= 0; s--) begin
         if (!mask[s]) begin
            idx   = SW'(s);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_snapshot_ctrl.sv
// Snapshot/restore controller: captures register-file dumps into slots and
// replays a slot back into the register file for one cycle on request.
module regfile_snapshot_ctrl
   import regfile_snapshot_pkg::*;
#(
   parameter int DTYPE_W = 8,
   parameter int NREGS   = 2,
   parameter int NSLOTS  = 4,
   localparam int SW = slot_idx_w(NSLOTS),
   localparam int DW = NREGS * DTYPE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DW-1:0]     snap_in,
   output logic [DW-1:0]     dump_data,
   output logic              dump_wr_en,
   input  logic              alloc_call,
   output logic              alloc_rdy,
   output logic [SW-1:0]     alloc_slot,
   input  logic              free_call,
   input  logic [SW-1:0]     free_slot,
   input  logic              restore_call,
   output logic              restore_rdy,
   input  logic [SW-1:0]     restore_slot,
   input  logic              restore_keep,
   output logic [NSLOTS-1:0] valid_mask,
   output logic              restore_err
);

   snap_state_t         state_reg;
   logic [NSLOTS-1:0]   valid_mask_reg;
   logic [NSLOTS-1:0]   valid_mask_next;
   logic [DW-1:0]       dump_data_reg;
   logic                dump_wr_en_reg;
   logic                restore_err_reg;
   logic [DW-1:0]       slot_mem_reg [NSLOTS];

   logic [SW-1:0]       free_idx;
   logic                free_found;
   logic                alloc_acc;
   logic                restore_acc;
   logic                restore_hit;
   logic                restore_miss;

   regfile_snapshot_prio_enc #(
      .NSLOTS (NSLOTS)
   ) u_prio_enc (
      .mask  (valid_mask_reg),
      .idx   (free_idx),
      .found (free_found)
   );

   assign alloc_rdy    = (state_reg == ST_IDLE) && free_found;
   assign restore_rdy  = (state_reg == ST_IDLE);
   assign alloc_slot   = free_found ? free_idx : '0;
   assign alloc_acc    = alloc_call && alloc_rdy;
   assign restore_acc  = restore_call && restore_rdy;
   assign restore_hit  = restore_acc && valid_mask_reg[restore_slot];
   assign restore_miss = restore_acc && !valid_mask_reg[restore_slot];

   // Clears first, then the alloc set: the alloc slot is always clear
   // pre-edge, so a free aimed at it is a no-op and must not cancel it.
   always_comb begin
      valid_mask_next = valid_mask_reg;
      if (free_call)
         valid_mask_next[free_slot] = 1'b0;
      if (restore_hit && !restore_keep)
         valid_mask_next[restore_slot] = 1'b0;
      if (alloc_acc)
         valid_mask_next[alloc_slot] = 1'b1;
   end

   // Slot storage is deliberately left out of reset.
   generate
      for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (alloc_acc && (alloc_slot == SW'(gi)))
               slot_mem_reg[gi] <= snap_in;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         valid_mask_reg  <= '0;
         dump_data_reg   <= '0;
         dump_wr_en_reg  <= 1'b0;
         restore_err_reg <= 1'b0;
      end else begin
         valid_mask_reg <= valid_mask_next;
         if (restore_miss)
            restore_err_reg <= 1'b1;
         case (state_reg)
            ST_IDLE: begin
               if (restore_hit) begin
                  state_reg      <= ST_DRIVE;
                  dump_data_reg  <= slot_mem_reg[restore_slot];
                  dump_wr_en_reg <= 1'b1;
               end
            end
            ST_DRIVE: begin
               state_reg      <= ST_IDLE;
               dump_data_reg  <= '0;
               dump_wr_en_reg <= 1'b0;
            end
            default: begin
               state_reg      <= ST_IDLE;
               dump_data_reg  <= '0;
               dump_wr_en_reg <= 1'b0;
            end
         endcase
      end
   end

   assign dump_data   = dump_data_reg;
   assign dump_wr_en  = dump_wr_en_reg;
   assign valid_mask  = valid_mask_reg;
   assign restore_err = restore_err_reg;

endmodule

// File: tb/tb_regfile_snapshot_ctrl.sv
// Table-driven bench for regfile_snapshot_ctrl with a dump-data scoreboard.
module tb_regfile_snapshot_ctrl;

   localparam int DTYPE_W = 8;
   localparam int NREGS   = 2;
   localparam int NSLOTS  = 4;
   localparam int SW      = 2;
   localparam int DW      = NREGS * DTYPE_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [DW-1:0]     snap_in;
   logic [DW-1:0]     dump_data;
   logic              dump_wr_en;
   logic              alloc_call;
   logic              alloc_rdy;
   logic [SW-1:0]     alloc_slot;
   logic              free_call;
   logic [SW-1:0]     free_slot;
   logic              restore_call;
   logic              restore_rdy;
   logic [SW-1:0]     restore_slot;
   logic              restore_keep;
   logic [NSLOTS-1:0] valid_mask;
   logic              restore_err;

   always #5 clk = ~clk;

   regfile_snapshot_ctrl #(
      .DTYPE_W (DTYPE_W),
      .NREGS   (NREGS),
      .NSLOTS  (NSLOTS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .snap_in      (snap_in),
      .dump_data    (dump_data),
      .dump_wr_en   (dump_wr_en),
      .alloc_call   (alloc_call),
      .alloc_rdy    (alloc_rdy),
      .alloc_slot   (alloc_slot),
      .free_call    (free_call),
      .free_slot    (free_slot),
      .restore_call (restore_call),
      .restore_rdy  (restore_rdy),
      .restore_slot (restore_slot),
      .restore_keep (restore_keep),
      .valid_mask   (valid_mask),
      .restore_err  (restore_err)
   );

   typedef struct {
      logic              alloc;
      logic              free;
      logic [SW-1:0]     fslot;
      logic              restore;
      logic [SW-1:0]     rslot;
      logic              keep;
      logic [DW-1:0]     snap;
      logic              e_ardy;
      logic              e_rrdy;
      logic [SW-1:0]     e_aslot;
      logic [NSLOTS-1:0] e_mask;
      logic              e_wr;
      logic              e_err;
      logic              push;
      logic [DW-1:0]     push_val;
   } vec_t;

   vec_t          tbl[$];
   logic [DW-1:0] sb_q[$];
   int            n_cmp = 0;
   int            n_err = 0;

   function automatic vec_t mk(
      input logic a, input logic f, input logic [SW-1:0] fs,
      input logic r, input logic [SW-1:0] rs, input logic k,
      input logic [DW-1:0] sn,
      input logic ea, input logic er, input logic [SW-1:0] eas,
      input logic [NSLOTS-1:0] em, input logic ew, input logic ee,
      input logic p, input logic [DW-1:0] pv);
      vec_t v;
      v.alloc = a;  v.free = f;  v.fslot = fs;
      v.restore = r; v.rslot = rs; v.keep = k; v.snap = sn;
      v.e_ardy = ea; v.e_rrdy = er; v.e_aslot = eas; v.e_mask = em;
      v.e_wr = ew; v.e_err = ee; v.push = p; v.push_val = pv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every write cycle must match the oldest pending expected restore.
   task automatic sb_check(input string tag);
      logic [DW-1:0] exp_v;
      if (dump_wr_en === 1'b1) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected_write: got data %0h expected no write", tag, dump_data);
         end else begin
            exp_v = sb_q.pop_front();
            if (dump_data !== exp_v) begin
               n_err++;
               $display("FAIL %s dump_data: got %0h expected %0h", tag, dump_data, exp_v);
            end
         end
      end else begin
         chk({tag, " dump_data_idle"}, 32'(dump_data), 32'd0);
      end
   endtask

   task automatic idle_inputs();
      alloc_call = 0; free_call = 0; free_slot = 0;
      restore_call = 0; restore_slot = 0; restore_keep = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1; snap_in = '0;
      idle_inputs();

      //          a f fs r rs k snap      ardy rrdy aslot mask    wr err push val
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h2211, 1,1,0, 4'b0000, 0,0, 0,16'h0));
      tbl.push_back(mk(0,0,0, 1,0,0, 16'h0000, 1,1,1, 4'b0001, 0,0, 1,16'h2211));
      tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 0,0,0, 4'b0000, 1,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h0001, 1,1,0, 4'b0000, 0,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h0002, 1,1,1, 4'b0001, 0,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h0003, 1,1,2, 4'b0011, 0,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h0004, 1,1,3, 4'b0111, 0,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h0005, 0,1,0, 4'b1111, 0,0, 0,16'h0));
      tbl.push_back(mk(0,1,2, 0,0,0, 16'h0000, 0,1,0, 4'b1111, 0,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h0006, 1,1,2, 4'b1011, 0,0, 0,16'h0));
      tbl.push_back(mk(0,1,3, 0,0,0, 16'h0007, 0,1,0, 4'b1111, 0,0, 0,16'h0));
      tbl.push_back(mk(1,0,0, 1,1,1, 16'h0008, 1,1,3, 4'b0111, 0,0, 1,16'h0002));
      tbl.push_back(mk(0,0,0, 0,0,0, 16'h0009, 0,0,0, 4'b1111, 1,0, 0,16'h0));
      tbl.push_back(mk(0,0,0, 1,3,0, 16'h0000, 0,1,0, 4'b1111, 0,0, 1,16'h0008));
      tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 0,0,3, 4'b0111, 1,0, 0,16'h0));
      tbl.push_back(mk(0,1,0, 1,0,1, 16'h0000, 1,1,3, 4'b0111, 0,0, 1,16'h0001));
      tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 0,0,0, 4'b0110, 1,0, 0,16'h0));
      tbl.push_back(mk(0,0,0, 1,3,0, 16'h0000, 1,1,0, 4'b0110, 0,0, 0,16'h0));
      tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 1,1,0, 4'b0110, 0,1, 0,16'h0));
      tbl.push_back(mk(1,1,1, 0,0,0, 16'h000a, 1,1,0, 4'b0110, 0,1, 0,16'h0));
      tbl.push_back(mk(1,0,0, 0,0,0, 16'h000b, 1,1,1, 4'b0101, 0,1, 0,16'h0));
      tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 1,1,3, 4'b0111, 0,1, 0,16'h0));

      repeat (2) @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         reset        = 0;
         alloc_call   = tbl[i].alloc;
         free_call    = tbl[i].free;
         free_slot    = tbl[i].fslot;
         restore_call = tbl[i].restore;
         restore_slot = tbl[i].rslot;
         restore_keep = tbl[i].keep;
         snap_in      = tbl[i].snap;
         if (tbl[i].push) sb_q.push_back(tbl[i].push_val);
         #1;
         chk($sformatf("row%0d alloc_rdy", i),   32'(alloc_rdy),   32'(tbl[i].e_ardy));
         chk($sformatf("row%0d restore_rdy", i), 32'(restore_rdy), 32'(tbl[i].e_rrdy));
         chk($sformatf("row%0d alloc_slot", i),  32'(alloc_slot),  32'(tbl[i].e_aslot));
         chk($sformatf("row%0d valid_mask", i),  32'(valid_mask),  32'(tbl[i].e_mask));
         chk($sformatf("row%0d dump_wr_en", i),  32'(dump_wr_en),  32'(tbl[i].e_wr));
         chk($sformatf("row%0d restore_err", i), 32'(restore_err), 32'(tbl[i].e_err));
         sb_check($sformatf("row%0d", i));
         $display("row%0d a=%0d f=%0d r=%0d rs=%0d mask=%b wr=%0d data=%h err=%0d",
                  i, alloc_call, free_call, restore_call, restore_slot,
                  valid_mask, dump_wr_en, dump_data, restore_err);
      end

      // Reset dominates simultaneous alloc and valid restore, and clears the sticky error.
      @(negedge clk);
      idle_inputs();
      reset = 1; alloc_call = 1; restore_call = 1; restore_slot = 2; snap_in = 16'h00ee;
      @(negedge clk);
      idle_inputs();
      reset = 0;
      #1;
      chk("rst_dom valid_mask",  32'(valid_mask),  32'd0);
      chk("rst_dom restore_err", 32'(restore_err), 32'd0);
      chk("rst_dom alloc_rdy",   32'(alloc_rdy),   32'd1);
      chk("rst_dom dump_wr_en",  32'(dump_wr_en),  32'd0);
      sb_check("rst_dom");
      $display("rst_dom mask=%b err=%0d wr=%0d", valid_mask, restore_err, dump_wr_en);

      // Reset arriving in the drive cycle cancels the FSM and clears everything.
      @(negedge clk);
      alloc_call = 1; snap_in = 16'h000c;
      @(negedge clk);
      idle_inputs();
      restore_call = 1; restore_slot = 0; restore_keep = 1;
      sb_q.push_back(16'h000c);
      @(negedge clk);
      idle_inputs();
      reset = 1; alloc_call = 1; restore_call = 1;
      #1;
      chk("drv_rst alloc_rdy_in_drive",   32'(alloc_rdy),   32'd0);
      chk("drv_rst restore_rdy_in_drive", 32'(restore_rdy), 32'd0);
      chk("drv_rst wr_in_drive",          32'(dump_wr_en),  32'd1);
      sb_check("drv_rst drive");
      @(negedge clk);
      idle_inputs();
      reset = 0;
      #1;
      chk("drv_rst dump_wr_en_after", 32'(dump_wr_en),  32'd0);
      chk("drv_rst valid_mask_after", 32'(valid_mask),  32'd0);
      chk("drv_rst restore_rdy",      32'(restore_rdy), 32'd1);
      sb_check("drv_rst after");
      @(negedge clk);
      #1;
      chk("drv_rst no_late_write", 32'(dump_wr_en), 32'd0);
      sb_check("drv_rst late");
      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("drv_rst mask=%b wr=%0d pending=%0d", valid_mask, dump_wr_en, sb_q.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
